// File: rtl/io_cfg_pkg.sv
// Shared constants and state encoding for the IO configuration loader.
// CFG_W is tied to the default IO count; the loader recomputes it from its own NIO.
package io_cfg_pkg;
    localparam int         NIO_DEF  = 16;
    localparam int         CFG_W    = 3 * NIO_DEF;
    localparam logic [7:0] SYNC_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT
    } state_t;
endpackage

// File: rtl/io_cfg_sipo.sv
// Serial-in/parallel-out shift register, MSB first, with enable and synchronous clear.
// Synchronous clear wins over enable.
module io_cfg_sipo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic         i_din,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_en)
            r_q <= {r_q[W-2:0], i_din};
    end

    assign o_q = r_q;
endmodule

// File: rtl/io_cfg_loader.sv
// Serial frame loader for IO block configuration: hunts a sync word, shifts config
// and checksum into shadow registers, and commits atomically only on a checksum match.
module io_cfg_loader
    import io_cfg_pkg::*;
#(
    parameter int         NIO  = NIO_DEF,
    parameter logic [7:0] SYNC = SYNC_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DVALID,
    input  logic             CLR,
    output logic [2*NIO-1:0] TSMUX_ALL,
    output logic [NIO-1:0]   DORREG_ALL,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);
    localparam int LW    = 3 * NIO;
    localparam int CNT_W = $clog2(LW);

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        w_hunt, w_chk, w_xor;
    logic [LW-1:0]     w_shadow;
    logic [2*NIO-1:0]  w_ts_new, r_ts;
    logic [NIO-1:0]    w_dor_new, r_dor;
    logic              r_done, r_err;
    logic              w_acc, w_hunt_en, w_hunt_clr, w_sync_hit, w_load_last, w_chk_last, w_match;

    // CLR outranks DVALID: a bit presented alongside CLR is never accepted
    assign w_acc       = DVALID & ~CLR;
    assign w_hunt_en   = w_acc && (r_state == ST_HUNT);
    assign w_sync_hit  = w_hunt_en && ({w_hunt[6:0], DIN} == SYNC);
    assign w_hunt_clr  = CLR | w_sync_hit | (r_state != ST_HUNT);
    assign w_load_last = w_acc && (r_state == ST_LOAD) && (r_cnt == CNT_W'(LW - 1));
    assign w_chk_last  = w_acc && (r_state == ST_CHECK) && (r_cnt == CNT_W'(7));

    io_cfg_sipo #(.W(8)) u_hunt (
        .clk(CLK), .rst(RST), .i_en(w_hunt_en), .i_clr(w_hunt_clr), .i_din(DIN), .o_q(w_hunt)
    );
    io_cfg_sipo #(.W(LW)) u_shadow (
        .clk(CLK), .rst(RST), .i_en(w_acc && (r_state == ST_LOAD)), .i_clr(CLR),
        .i_din(DIN), .o_q(w_shadow)
    );
    io_cfg_sipo #(.W(8)) u_chk (
        .clk(CLK), .rst(RST), .i_en(w_acc && (r_state == ST_CHECK)), .i_clr(CLR),
        .i_din(DIN), .o_q(w_chk)
    );

    always_comb begin
        w_xor = '0;
        for (int b = 0; b < LW / 8; b++)
            w_xor = w_xor ^ w_shadow[b*8 +: 8];
    end
    assign w_match = (w_chk == w_xor);

    // Shadow triplet i is {TSMUX[1:0], DORREG} for IO block i
    generate
        for (genvar gi = 0; gi < NIO; gi++) begin : g_unpack
            assign w_ts_new[2*gi +: 2] = w_shadow[3*gi+1 +: 2];
            assign w_dor_new[gi]       = w_shadow[3*gi];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_HUNT;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT:   if (w_sync_hit)  w_state_next = ST_LOAD;
            ST_LOAD:   if (w_load_last) w_state_next = ST_CHECK;
            ST_CHECK:  if (w_chk_last)  w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_HUNT;
            default:   w_state_next = ST_HUNT;
        endcase
        if (CLR)
            w_state_next = ST_HUNT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (CLR || w_sync_hit || w_load_last || w_chk_last)
            r_cnt <= '0;
        else if (w_acc && (r_state == ST_LOAD || r_state == ST_CHECK))
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ts   <= '0;
            r_dor  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (CLR || w_sync_hit)
                r_err <= 1'b0;
            else if (r_state == ST_COMMIT) begin
                if (w_match) begin
                    r_ts   <= w_ts_new;
                    r_dor  <= w_dor_new;
                    r_done <= 1'b1;
                end else
                    r_err  <= 1'b1;
            end
        end
    end

    assign TSMUX_ALL  = r_ts;
    assign DORREG_ALL = r_dor;
    assign BUSY       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign DONE       = r_done;
    assign ERR        = r_err;
endmodule

// File: tb/tb_io_cfg_loader.sv
// Randomised scoreboard bench for io_cfg_loader: frames are pushed as expected commits
// or checksum errors, and a monitor matches each DONE/ERR event by cycle and value.
module tb_io_cfg_loader;
    localparam logic [7:0] SYNC_V = 8'hA5;

    logic        CLK = 1'b0;
    logic        RST, DIN, DVALID, CLR;
    logic [31:0] TSMUX_ALL;
    logic [15:0] DORREG_ALL;
    logic        BUSY, DONE, ERR;

    typedef struct {
        bit          good;
        int          cyc;
        logic [31:0] ts;
        logic [15:0] dor;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] cur_ts = '0;
    logic [15:0] cur_dor = '0;

    io_cfg_loader dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DVALID(DVALID), .CLR(CLR),
        .TSMUX_ALL(TSMUX_ALL), .DORREG_ALL(DORREG_ALL), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [47:0] cfg);
        logic [7:0] x = '0;
        for (int b = 0; b < 6; b++) x ^= cfg[b*8 +: 8];
        return x;
    endfunction

    // IO block i takes the i-th 3-bit group of the config word as {tsmux, dorreg}
    function automatic void apply_cfg(input logic [47:0] cfg);
        for (int i = 0; i < 16; i++) begin
            cur_ts[2*i +: 2] = cfg[3*i+1 +: 2];
            cur_dor[i]       = cfg[3*i];
        end
    endfunction

    // mode 0: no gaps, 1: DVALID low every other cycle, 2: random gaps
    task automatic send_bit(input logic b, input int mode, input bit busy_chk);
        int g;
        g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(negedge CLK);
            if (busy_chk) chk("busy_in_frame", BUSY, 1);
            DVALID = 1'b0;
            DIN    = 1'($urandom);
        end
        @(negedge CLK);
        if (busy_chk) chk("busy_in_frame", BUSY, 1);
        DIN    = b;
        DVALID = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] cfg, input logic [7:0] ck, input int mode,
                              input int ncfg, input bit errchk);
        exp_t       e;
        logic [7:0] s;
        s = SYNC_V;
        for (int i = 7; i >= 0; i--) send_bit(s[i], mode, 1'b0);
        if (errchk) begin
            @(posedge CLK); #1;
            chk("err_clear_at_sync", ERR, 0);
            chk("busy_after_sync", BUSY, 1);
        end
        for (int i = 0; i < ncfg; i++) send_bit(cfg[47-i], mode, 1'b1);
        if (ncfg < 48) return;
        for (int i = 7; i >= 0; i--) send_bit(ck[i], mode, 1'b1);
        e.cyc  = cyc + 2;
        e.good = (ck == xsum(cfg));
        if (e.good) apply_cfg(cfg);
        e.ts  = cur_ts;
        e.dor = cur_dor;
        sb.push_back(e);
        @(negedge CLK);
        DVALID = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic prev_err = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (RST) begin
                prev_err = 1'b0;
                continue;
            end
            if (DONE || (ERR && !prev_err)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event_done", {63'd0, DONE}, 0);
                    chk("unexpected_event_err", {63'd0, ERR}, 0);
                end else begin
                    e = sb.pop_front();
                    $display("event cycle %0d done=%0b err=%0b ts=%08h dor=%04h", cyc, DONE, ERR,
                             TSMUX_ALL, DORREG_ALL);
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_flag", DONE, e.good);
                    chk("err_flag", ERR, !e.good);
                    chk("tsmux_all", TSMUX_ALL, e.ts);
                    chk("dorreg_all", DORREG_ALL, e.dor);
                end
            end
            prev_err = ERR;
        end
    end

    initial begin
        logic [47:0] cfg;
        logic [7:0]  ck;
        RST = 1'b1; DIN = 1'b0; DVALID = 1'b0; CLR = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_tsmux", TSMUX_ALL, 0);
        chk("reset_dorreg", DORREG_ALL, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_err", ERR, 0);
        chk("reset_done", DONE, 0);

        send_frame(48'hFFFF_FFFF_FFFF, 8'h00, 0, 48, 1'b0);
        send_frame(48'hFFFF_FFFF_FFFF, 8'h01, 0, 48, 1'b0);
        repeat (2) @(negedge CLK);
        chk("err_sticky", ERR, 1);

        cfg = {$urandom, $urandom};
        send_frame(cfg, xsum(cfg), 1, 48, 1'b1);

        // abort at config bit 20, then a full frame must still commit
        cfg = {$urandom, $urandom};
        send_frame(cfg, xsum(cfg), 0, 20, 1'b0);
        @(negedge CLK);
        CLR = 1'b1; DVALID = 1'b1; DIN = 1'b1;
        @(negedge CLK);
        CLR = 1'b0; DVALID = 1'b0;
        chk("clr_busy", BUSY, 0);
        chk("clr_tsmux_kept", TSMUX_ALL, cur_ts);
        chk("clr_dorreg_kept", DORREG_ALL, cur_dor);
        send_frame(cfg, xsum(cfg), 0, 48, 1'b0);

        send_frame(48'hA5A5_A5A5_A5A5, 8'h00, 2, 48, 1'b0);

        for (int n = 0; n < 12; n++) begin
            cfg = {$urandom, $urandom};
            ck  = xsum(cfg);
            if ($urandom_range(0, 3) == 0) ck ^= 8'(1 << $urandom_range(0, 7));
            send_frame(cfg, ck, 2, 48, 1'b0);
        end

        // asynchronous reset between edges at config bit 30 of an A5-laden frame
        send_frame(48'hA5A5_A5A5_A5A5, 8'h00, 0, 30, 1'b0);
        @(negedge CLK);
        DVALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("async_rst_tsmux", TSMUX_ALL, 0);
        chk("async_rst_dorreg", DORREG_ALL, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_err", ERR, 0);
        #1 RST = 1'b0;
        cur_ts  = '0;
        cur_dor = '0;
        send_frame(48'h5A5A_A5A5_0F0F, xsum(48'h5A5A_A5A5_0F0F), 0, 48, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
